data_memory_ctrl: RTL and testbench
===================================

Name: data_memory_ctrl

Overview:
- Parametrised successor to the single-cycle data memory; sits in the MEM stage of the datapath.
- Accepts byte-addressed load/store requests with byte/half/word/double sizes and sign/zero extension.
- Uses a valid/ready request channel and a registered, back-pressurable response channel.
- Clears itself word-by-word after reset and flags misaligned or oversized accesses.

Parameters:
- DATA_W, 64, word width in bits; legal values 32 or 64.
- DEPTH, 64, number of words; must be a power of two.
- BYTES, DATA_W/8, derived: bytes per word.
- ADDR_W, log2(DEPTH*BYTES), derived: byte-address width.

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  request accepted when req_valid && req_ready.
- req_write  in  1  1 = store, 0 = load.
- req_size  in  2  0 = byte, 1 = half, 2 = word(32), 3 = double(64).
- req_unsigned  in  1  loads: zero-extend when 1, sign-extend when 0.
- req_addr  in  ADDR_W  byte address.
- req_wdata  in  DATA_W  store data, right-aligned (LSBs).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  response consumed when rsp_valid && rsp_ready.
- rsp_rdata  out  DATA_W  extended load data; 0 for stores and errors.
- rsp_err  out  1  misaligned or oversized access.
- init_done  out  1  high once the clear sweep has finished.

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low.
- Reset values: state = INIT, clear counter = 0, req_ready = 0, rsp_valid = 0, rsp_rdata = 0, rsp_err = 0, init_done = 0.
- INIT state:
  - Writes 0 to word[cnt] each cycle; cnt increments.
  - After word DEPTH-1 is cleared, moves to RUN and sets init_done = 1. Sweep takes exactly DEPTH cycles after reset release.
  - req_ready stays 0 throughout.
- RUN state:
  - req_ready = !rsp_valid || rsp_ready, so a response can be consumed and a new request accepted in the same cycle.
- Address decode:
  - Word index = req_addr[ADDR_W-1 : log2(BYTES)].
  - Byte offset = req_addr[log2(BYTES)-1 : 0].
- Error check:
  - err = (2^req_size > BYTES) || (offset mod 2^req_size != 0).
  - On error, no array write occurs; the response carries rsp_err = 1 and rsp_rdata = 0.
- Store:
  - On the accepting edge, only bytes offset .. offset+2^size-1 of the word are updated, taken from the low bytes of req_wdata. Other bytes are unchanged.
  - Response on the next cycle: rsp_valid = 1, rsp_rdata = 0.
- Load:
  - On the accepting edge, the selected bytes are extracted and shifted to the LSBs.
  - Extension: sign-extend from the field MSB, or zero-extend when req_unsigned = 1.
  - The result is registered into rsp_rdata; rsp_valid = 1 on the next cycle. Latency is one cycle.
- Response hold: rsp_valid, rsp_rdata and rsp_err stay stable while rsp_valid && !rsp_ready. rsp_valid clears when the response is consumed and no new request is accepted.
- Read-after-write: a store accepted at edge N is visible to a load accepted at edge N+1. There is no same-edge hazard, since only one request is accepted per edge.
- Simultaneous events: consuming a response and accepting a request on the same edge loads the new response without a bubble.
- Reset mid-operation: any in-flight response is dropped and the INIT sweep restarts; memory contents after the sweep are all zero.
- req_ready never depends combinationally on req_valid.

Decomposition:
- Package data_mem_pkg holds:
  - size enum: SZ_B, SZ_H, SZ_W, SZ_D.
  - state enum: INIT, RUN.
  - functions size_bytes() and is_misaligned().
- One sub-module, data_mem_lane_fmt (combinational):
  - Store path: byte-enable and shifted write-data generation.
  - Load path: byte extraction and sign/zero extension.
- The top level keeps the array, the FSM and the response register.

Test Plan:
- Reset, then hold rsp_ready = 1 -> init_done rises exactly 64 cycles after rst_n deasserts; a load of addr 0x1F8 (size 3) returns 0.
- Store double 0x1122334455667788 at 0x08, then load byte at 0x0F:
  - signed load -> rsp_rdata = 0x11.
  - load half at 0x0C -> 0x3344.
- Store byte 0xF0 at 0x10, then load byte at 0x10:
  - signed -> 0xFFFFFFFFFFFFFFF0.
  - unsigned -> 0xF0.
  - Neighbouring bytes at 0x11 still read 0.
- Misaligned accesses: store word at 0x06 -> rsp_err = 1, rsp_rdata = 0; a subsequent load of word 0x04 shows no change. Load half at 0x03 -> rsp_err = 1.
- Backpressure: rsp_ready = 0 for 3 cycles after a load -> req_ready = 0 and the response is held stable. Raising rsp_ready with req_valid high gives back-to-back accept with no idle cycle.
- Assert rst_n low while rsp_valid = 1 -> rsp_valid = 0 immediately (asynchronous). After release, the INIT sweep repeats, and a previously written 0x08 reads 0.

Source files
------------

// File: rtl/data_mem_pkg.sv
// data_mem_pkg: access-size and FSM types plus size/alignment helpers shared by the data memory controller.
package data_mem_pkg;
    typedef enum logic [1:0] {SZ_B, SZ_H, SZ_W, SZ_D} size_e;
    typedef enum logic {INIT, RUN} state_e;
    function automatic int size_bytes(input logic [1:0] size);
        return 1 << size;
    endfunction
    // Also flags accesses wider than a word so a 32-bit build rejects doubles.
    function automatic logic is_misaligned(input logic [1:0] size, input int offset, input int bytes);
        return (size_bytes(size) > bytes) || (offset % size_bytes(size) != 0);
    endfunction
endpackage

// File: rtl/data_mem_lane_fmt.sv
// data_mem_lane_fmt: byte-lane steering for stores and field extraction with sign/zero extension for loads.
module data_mem_lane_fmt
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int BYTES  = DATA_W / 8,
    parameter int OFF_W  = $clog2(BYTES)
) (
    input  logic [1:0]        size,
    input  logic              is_unsigned,
    input  logic [OFF_W-1:0]  offset,
    input  logic [DATA_W-1:0] wdata,
    input  logic [DATA_W-1:0] rword,
    output logic [BYTES-1:0]  be,
    output logic [DATA_W-1:0] wdata_sh,
    output logic [DATA_W-1:0] rdata_ext
);
    logic [DATA_W-1:0] field, mask;
    logic sign;
    // A shift by the full width yields 0, so "minus one" gives an all-ones mask for full-word sizes.
    always_comb begin
        be = ((BYTES'(1) << size_bytes(size)) - BYTES'(1)) << offset;
        wdata_sh = wdata << {offset, 3'b000};
        field = rword >> {offset, 3'b000};
        mask = (DATA_W'(1) << (8 * size_bytes(size))) - DATA_W'(1);
        sign = !is_unsigned && |(field & (DATA_W'(1) << (8 * size_bytes(size) - 1)));
        rdata_ext = (field & mask) | (sign ? ~mask : '0);
    end
endmodule

// File: rtl/data_memory_ctrl.sv
// data_memory_ctrl: MEM-stage data memory with a clear sweep after reset, a valid/ready request channel
// and a registered, back-pressurable response carrying extended load data or an alignment error.
module data_memory_ctrl
    import data_mem_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int DEPTH  = 64,
    parameter int BYTES  = DATA_W / 8,
    parameter int ADDR_W = $clog2(DEPTH * BYTES)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [1:0]        req_size,
    input  logic              req_unsigned,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              init_done
);
    localparam int OFF_W = $clog2(BYTES);
    localparam int IDX_W = $clog2(DEPTH);

    state_e state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d, idx, wr_idx;
    logic rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [OFF_W-1:0] offset;
    logic [BYTES-1:0] be, wr_be;
    logic [DATA_W-1:0] wdata_sh, rdata_ext, wr_data;
    logic accept, err, wr_en;

    assign idx    = req_addr[ADDR_W-1:OFF_W];
    assign offset = req_addr[OFF_W-1:0];
    assign err    = is_misaligned(req_size, int'(offset), BYTES);
    assign accept = req_valid && req_ready;

    data_mem_lane_fmt #(.DATA_W(DATA_W), .BYTES(BYTES)) u_fmt (
        .size        (req_size),
        .is_unsigned (req_unsigned),
        .offset      (offset),
        .wdata       (req_wdata),
        .rword       (mem_q[idx]),
        .be          (be),
        .wdata_sh    (wdata_sh),
        .rdata_ext   (rdata_ext)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= INIT;
            cnt_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        state_d = (state_q == INIT && cnt_q == IDX_W'(DEPTH - 1)) ? RUN : state_q;
        cnt_d = state_q == INIT ? cnt_q + 1'b1 : cnt_q;
    end

    always_comb begin
        init_done = state_q == RUN;
        req_ready = state_q == RUN && (!rsp_valid_q || rsp_ready);
    end

    // The clear sweep owns the write port until RUN; errored stores never reach the array.
    always_comb begin
        wr_en = state_q == INIT || (accept && req_write && !err);
        wr_idx = state_q == INIT ? cnt_q : idx;
        wr_be = state_q == INIT ? '1 : be;
        wr_data = state_q == INIT ? '0 : wdata_sh;
    end

    always_ff @(posedge clk) begin
        if (wr_en)
            for (int b = 0; b < BYTES; b++)
                if (wr_be[b]) mem_q[wr_idx][b*8 +: 8] <= wr_data[b*8 +: 8];
    end

    always_comb begin
        rsp_valid_d = accept || (rsp_valid_q && !rsp_ready);
        rsp_err_d = accept ? err : rsp_err_q;
        rsp_rdata_d = accept ? ((err || req_write) ? '0 : rdata_ext) : rsp_rdata_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rsp_valid_q <= 1'b0;
            rsp_err_q <= 1'b0;
            rsp_rdata_q <= '0;
        end else begin
            rsp_valid_q <= rsp_valid_d;
            rsp_err_q <= rsp_err_d;
            rsp_rdata_q <= rsp_rdata_d;
        end
    end

    assign rsp_valid = rsp_valid_q;
    assign rsp_err   = rsp_err_q;
    assign rsp_rdata = rsp_rdata_q;
endmodule

// File: tb/tb_data_memory_ctrl.sv
// tb_data_memory_ctrl: directed and randomized load/store traffic checked against a byte-array memory model.
module tb_data_memory_ctrl;
    localparam int NB = 64 * 8;

    logic clk = 1'b0, rst_n = 1'b0;
    logic req_valid = 1'b0, req_write = 1'b0, req_unsigned = 1'b0, rsp_ready = 1'b1;
    logic [1:0] req_size = '0;
    logic [8:0] req_addr = '0;
    logic [63:0] req_wdata = '0;
    logic req_ready, rsp_valid, rsp_err, init_done;
    logic [63:0] rsp_rdata;
    int checks = 0, errors = 0;
    logic [7:0] mem_m [NB];

    always #5 clk = ~clk;

    data_memory_ctrl dut (
        .clk(clk), .rst_n(rst_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
        .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .init_done(init_done)
    );

    function automatic bit m_err(int sz, int a);
        return (a % (1 << sz)) != 0;
    endfunction

    function automatic logic [63:0] m_load(int sz, bit u, int a);
        int n = 1 << sz;
        logic [63:0] v = '0;
        for (int k = 0; k < n; k++) v = v | (64'(mem_m[a + k]) << (8 * k));
        if (!u && ((v >> (8 * n - 1)) & 64'd1) == 64'd1) v = v | ~((64'd1 << (8 * n)) - 64'd1);
        return v;
    endfunction

    task automatic m_store(int sz, int a, logic [63:0] wd);
        for (int k = 0; k < (1 << sz); k++) mem_m[a + k] = 8'(wd >> (8 * k));
    endtask

    task automatic m_clear();
        for (int k = 0; k < NB; k++) mem_m[k] = 8'h00;
    endtask

    // Called at a negedge; returns at the negedge after the accepting edge with the response visible.
    task automatic txn(input bit w, input int sz, input bit u, input int a, input logic [63:0] wd,
                       output logic [63:0] d, output logic e);
        int t = 0;
        req_valid = 1'b1; req_write = w; req_size = 2'(sz); req_unsigned = u;
        req_addr = 9'(a); req_wdata = wd;
        while (!req_ready && t < 200) begin @(negedge clk); t++; end
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL accept_timeout addr=%0h req_ready=%b required 1", a, req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1) begin
            errors++;
            $display("FAIL rsp_latency addr=%0h rsp_valid=%b required 1", a, rsp_valid);
        end
        d = rsp_rdata; e = rsp_err;
    endtask

    task automatic wait_init(input string tag);
        int cyc = 0, bad = 0;
        @(negedge clk);
        rst_n = 1'b1;
        while (!init_done && cyc < 200) begin
            @(posedge clk); #1;
            cyc++;
            if (req_ready && !init_done) bad++;
        end
        checks++;
        if (cyc !== 64 || init_done !== 1'b1) begin
            errors++;
            $display("FAIL %s init_cycles=%0d init_done=%b required 64 and 1", tag, cyc, init_done);
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL %s ready_during_init count=%0d required 0", tag, bad);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        logic [63:0] d;
        logic e;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if ({req_ready, rsp_valid, rsp_err, init_done} !== 4'b0000 || rsp_rdata !== 64'd0) begin
            errors++;
            $display("FAIL reset_outputs ready/valid/err/done=%b%b%b%b rdata=%h required 0000 and 0",
                     req_ready, rsp_valid, rsp_err, init_done, rsp_rdata);
        end
        m_clear();
        wait_init("reset");
        txn(1'b0, 3, 1'b0, 'h1F8, 64'd0, d, e);
        checks++;
        if (d !== 64'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL cleared_load rdata=%h err=%b required 0 and 0", d, e);
        end
    endtask

    typedef struct {
        bit w; int sz; bit u; int a; logic [63:0] wd; logic [63:0] ed; bit ee;
    } op_t;

    task automatic test_directed();
        op_t ops[11] = '{
            '{1'b1, 3, 1'b0, 'h08, 64'h1122334455667788, 64'd0, 1'b0},
            '{1'b0, 0, 1'b0, 'h0F, 64'd0, 64'h11, 1'b0},
            '{1'b0, 1, 1'b0, 'h0C, 64'd0, 64'h3344, 1'b0},
            '{1'b1, 0, 1'b0, 'h10, 64'hF0, 64'd0, 1'b0},
            '{1'b0, 0, 1'b0, 'h10, 64'd0, 64'hFFFFFFFFFFFFFFF0, 1'b0},
            '{1'b0, 0, 1'b1, 'h10, 64'd0, 64'hF0, 1'b0},
            '{1'b0, 0, 1'b0, 'h11, 64'd0, 64'd0, 1'b0},
            '{1'b1, 2, 1'b0, 'h06, 64'hDEADBEEF, 64'd0, 1'b1},
            '{1'b0, 2, 1'b1, 'h04, 64'd0, 64'd0, 1'b0},
            '{1'b0, 1, 1'b0, 'h03, 64'd0, 64'd0, 1'b1},
            '{1'b0, 3, 1'b0, 'h08, 64'd0, 64'h1122334455667788, 1'b0}
        };
        logic [63:0] d;
        logic e;
        foreach (ops[i]) begin
            txn(ops[i].w, ops[i].sz, ops[i].u, ops[i].a, ops[i].wd, d, e);
            if (ops[i].w && !ops[i].ee) m_store(ops[i].sz, ops[i].a, ops[i].wd);
            checks++;
            if (d !== ops[i].ed || e !== ops[i].ee) begin
                errors++;
                $display("FAIL directed[%0d] addr=%0h rdata=%h err=%b required %h %b",
                         i, ops[i].a, d, e, ops[i].ed, ops[i].ee);
            end
        end
    endtask

    task automatic test_random();
        logic [63:0] d, ed, wd;
        logic e;
        bit w, u, ee;
        int sz, a;
        for (int i = 0; i < 300; i++) begin
            sz = $urandom_range(0, 3);
            a = $urandom_range(0, NB - 1);
            if ($urandom_range(0, 3) != 0) a = a & ~((1 << sz) - 1);
            w = 1'($urandom_range(0, 1));
            u = 1'($urandom_range(0, 1));
            wd = {$urandom, $urandom};
            ee = m_err(sz, a);
            ed = (ee || w) ? 64'd0 : m_load(sz, u, a);
            txn(w, sz, u, a, wd, d, e);
            if (w && !ee) m_store(sz, a, wd);
            checks++;
            if (d !== ed || e !== ee) begin
                errors++;
                $display("FAIL random[%0d] w=%b sz=%0d u=%b addr=%0h rdata=%h err=%b required %h %b",
                         i, w, sz, u, a, d, e, ed, ee);
            end
        end
    endtask

    task automatic test_backpressure();
        logic [63:0] d, first;
        logic e;
        int bad = 0;
        @(negedge clk);
        rsp_ready = 1'b0;
        first = m_load(3, 1'b0, 'h08);
        txn(1'b0, 3, 1'b0, 'h08, 64'd0, d, e);
        req_valid = 1'b1; req_write = 1'b0; req_size = 2'd0; req_unsigned = 1'b1;
        req_addr = 9'h0F; req_wdata = '0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            if (rsp_valid !== 1'b1 || rsp_rdata !== first || rsp_err !== 1'b0 || req_ready !== 1'b0) bad++;
        end
        checks++;
        if (bad !== 0) begin
            errors++;
            $display("FAIL bp_hold bad_cycles=%0d valid=%b rdata=%h ready=%b required 0 1 %h 0",
                     bad, rsp_valid, rsp_rdata, req_ready, first);
        end
        rsp_ready = 1'b1;
        #1;
        checks++;
        if (req_ready !== 1'b1) begin
            errors++;
            $display("FAIL bp_release req_ready=%b required 1", req_ready);
        end
        @(negedge clk);
        req_valid = 1'b0;
        checks++;
        if (rsp_valid !== 1'b1 || rsp_rdata !== m_load(0, 1'b1, 'h0F)) begin
            errors++;
            $display("FAIL back_to_back valid=%b rdata=%h required 1 %h",
                     rsp_valid, rsp_rdata, m_load(0, 1'b1, 'h0F));
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        logic [63:0] d;
        logic e;
        rsp_ready = 1'b0;
        txn(1'b0, 3, 1'b0, 'h08, 64'd0, d, e);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (rsp_valid !== 1'b0 || init_done !== 1'b0 || req_ready !== 1'b0) begin
            errors++;
            $display("FAIL async_reset valid=%b done=%b ready=%b required 0 0 0",
                     rsp_valid, init_done, req_ready);
        end
        m_clear();
        rsp_ready = 1'b1;
        wait_init("mid_reset");
        txn(1'b0, 3, 1'b0, 'h08, 64'd0, d, e);
        checks++;
        if (d !== 64'd0 || e !== 1'b0) begin
            errors++;
            $display("FAIL post_reset_load rdata=%h err=%b required 0 0", d, e);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_backpressure();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog time limit reached");
        $fatal(1);
    end
endmodule
